// File: rtl/instr_fetch_pkg.sv
// Shared processor definitions for the instruction fetch stage: the fetch
// controller state encoding and the default address / counter widths.
package instr_fetch_pkg;

  localparam int PC_W_DEFAULT  = 10;
  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch controller. Sequences the program counter through a run,
// resolving stalls, absolute jumps and relative branches whose targets come
// from an external lookup table addressed by the current instruction's key.
// Also counts the cycles spent running, saturating at all-ones.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             jump_en,
  input  logic             branch_en,
  input  logic [3:0]       key_in,
  input  logic             halt_req,
  output logic [3:0]       lut_key,
  input  logic [7:0]       lut_value,
  output logic [PC_W-1:0]  pc,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  fetch_state_e   state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Jump targets are unsigned table entries; branch offsets are two's
  // complement, so they are sign-extended before the modular add.
  logic [PC_W-1:0] jumpTarget;
  logic [PC_W-1:0] branchOffset;

  assign jumpTarget   = PC_W'(lut_value);
  assign branchOffset = PC_W'($signed(lut_value));

  // The lookup key passes straight through so the table answers in the same
  // cycle the instruction is presented.
  assign lut_key     = key_in;
  assign pc          = pc_q;
  assign cycle_count = cnt_q;
  assign done        = (state_q == DONE);

  // Next-state, next-pc and next-count selection; everything holds unless a
  // transition or a RUN cycle says otherwise.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (halt_req) begin
          state_d = DONE;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (jump_en) begin
          pc_d = jumpTarget;
        end else if (branch_en) begin
          pc_d = pc_q + branchOffset;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // All fetch state lives in this one register process; reset overrides any
  // start or control input arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. Two instances share every input: the main
// one uses default widths, the second uses a 4-bit cycle counter so that
// saturation is reached within a short run. Expected results are pushed to a
// scoreboard as each step is driven and popped after the clock edge.
module tb_instr_fetch;

  typedef struct {
    int   pc;
    int   cnt;
    int   satCnt;
    logic done;
  } expect_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stall;
  logic       jump_en;
  logic       branch_en;
  logic [3:0] key_in;
  logic       halt_req;

  logic [3:0]  lut_key;
  logic [7:0]  lut_value;
  logic [9:0]  pc;
  logic        done;
  logic [15:0] cycle_count;

  logic [3:0]  lut_key_s;
  logic [7:0]  lut_value_s;
  logic [9:0]  pc_s;
  logic        done_s;
  logic [3:0]  cycle_count_s;

  logic [7:0] lutTable [16];

  expect_t sb[$];
  int nAsserts = 0;
  int nFail    = 0;

  assign lut_value   = lutTable[lut_key];
  assign lut_value_s = lutTable[lut_key_s];

  instr_fetch #(.PC_W(10), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .jump_en(jump_en), .branch_en(branch_en), .key_in(key_in),
    .halt_req(halt_req), .lut_key(lut_key), .lut_value(lut_value),
    .pc(pc), .done(done), .cycle_count(cycle_count)
  );

  instr_fetch #(.PC_W(10), .CNT_W(4)) dutSat (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .jump_en(jump_en), .branch_en(branch_en), .key_in(key_in),
    .halt_req(halt_req), .lut_key(lut_key_s), .lut_value(lut_value_s),
    .pc(pc_s), .done(done_s), .cycle_count(cycle_count_s)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic popAndCheck();
    expect_t e;
    nAsserts++;
    assert (sb.size() > 0) else begin
      nFail++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("pc", 16'(pc), 16'(e.pc));
      checkOutput("cycle_count", cycle_count, 16'(e.cnt));
      checkOutput("done", 16'(done), 16'(e.done));
      checkOutput("pc_sat", 16'(pc_s), 16'(e.pc));
      checkOutput("cycle_count_sat", 16'(cycle_count_s), 16'(e.satCnt));
    end
  endtask

  // One directed step: drive inputs mid-cycle, check the combinational lookup
  // key, then compare the registered outputs just after the next rising edge.
  task automatic applyStimulus(input logic rst, input logic st, input logic stl,
                               input logic jmp, input logic br, input logic hlt,
                               input logic [3:0] key, input int ePc,
                               input int eCnt, input logic eDone);
    expect_t e;
    @(negedge clk);
    reset     = rst;
    start     = st;
    stall     = stl;
    jump_en   = jmp;
    branch_en = br;
    halt_req  = hlt;
    key_in    = key;
    e.pc      = ePc;
    e.cnt     = eCnt;
    e.satCnt  = (eCnt > 15) ? 15 : eCnt;
    e.done    = eDone;
    sb.push_back(e);
    #1;
    checkOutput("lut_key", 16'(lut_key), 16'(key));
    checkOutput("lut_key_sat", 16'(lut_key_s), 16'(key));
    @(posedge clk);
    #1;
    popAndCheck();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stall = 1'b0; jump_en = 1'b0;
    branch_en = 1'b0; halt_req = 1'b0; key_in = 4'd0;
    for (int i = 0; i < 16; i++) lutTable[i] = 8'h00;
    lutTable[1] = 8'h02;
    lutTable[2] = 8'h09;
    lutTable[3] = 8'h2A;
    lutTable[4] = 8'h14;
    lutTable[5] = 8'hFC;
    lutTable[6] = 8'h0F;
    lutTable[7] = 8'h05;

    // rst st stl jmp br hlt key  pc cnt done
    applyStimulus(1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 4'd0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) applyStimulus(0, 0, 0, 0, 0, 0, 4'd0, i, i, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 4'd3, 42, 8, 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 4'd3, 42, 9, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 4'd1, 2, 10, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 4'd5, 1022, 11, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 4'd0, 1023, 12, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 4'd0, 0, 13, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 4'd5, 252, 14, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 4'd2, 9, 15, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 0, 4'd0, 9, 16 + i, 0);
    applyStimulus(0, 0, 1, 1, 0, 0, 4'd3, 9, 19, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 4'd4, 20, 20, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 4'd0, 20, 21, 1);
    applyStimulus(0, 0, 1, 1, 1, 1, 4'd3, 20, 21, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 4'd0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 4'd0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 4'd7, 6, 2, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 4'd6, 15, 3, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 4'd0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 1, 4'd3, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 4'd0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 4'd0, 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter PC_W, default 10, meaning program counter width (instruction memory depth 2**PC_W).
REQ-002 SHALL have parameter CNT_W, default 16, meaning cycle counter width.
REQ-003 SHALL have port clk  input  1  system clock; one clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  single-cycle pulse; begins program run.
REQ-006 SHALL have port stall  input  1  hold PC this cycle.
REQ-007 SHALL have port jump_en  input  1  absolute jump to lookup target.
REQ-008 SHALL have port branch_en  input  1  taken relative branch by lookup offset; condition is evaluated externally.
REQ-009 SHALL have port key_in  input  4  jump/branch selector field from the current instruction.
REQ-010 SHALL have port halt_req  input  1  end-of-program request.
REQ-011 SHALL have port lut_key  output  4  key driven to the downstream lookup table.
REQ-012 SHALL have port lut_value  input  8  target or offset returned by the lookup table.
REQ-013 SHALL have port pc  output  PC_W  current instruction address.
REQ-014 SHALL have port done  output  1  program halted.
REQ-015 SHALL have port cycle_count  output  CNT_W  cycles spent in RUN.

Function
REQ-016 SHALL drive lut_key = key_in combinationally, with zero latency, in every state.
REQ-017 SHALL implement states IDLE, RUN and DONE.
- IDLE -> RUN on start.
- RUN -> DONE on halt_req.
- DONE -> RUN on start.
- No other transitions.
REQ-018 SHALL, on entry to RUN, load pc = 0 and cycle_count = 0 in the same edge that leaves IDLE or DONE.
REQ-019 SHALL, in RUN, select next pc with this priority:
- halt_req: pc holds.
- stall: pc holds.
- jump_en: pc = zero-extended lut_value.
- branch_en: pc = pc + sign-extended lut_value, modulo 2**PC_W.
- otherwise: pc = pc + 1, modulo 2**PC_W.
REQ-020 SHALL make every pc update visible exactly one cycle after the controlling inputs are sampled; no delay slots.
REQ-021 SHALL give jump_en precedence when jump_en and branch_en are asserted together.
REQ-022 SHALL wrap pc from 2**PC_W-1 to 0 on increment; a branch below 0 also wraps, e.g. 2 + (-4) = 1022 for PC_W = 10.
REQ-023 SHALL increment cycle_count on every RUN cycle, including stall and halt cycles, and saturate it at all-ones.
REQ-024 SHALL hold pc and cycle_count in IDLE and DONE.
REQ-025 SHALL assert done only in DONE.
REQ-026 SHALL ignore start while in RUN.
REQ-027 SHALL ignore stall, jump_en, branch_en and halt_req in IDLE and DONE.

Reset
REQ-028 SHALL, on reset, set state = IDLE, pc = 0, done = 0 and cycle_count = 0 on the next rising clk edge.
REQ-029 SHALL give reset priority over every other input, including mid-RUN and simultaneous with start.
REQ-030 SHALL NOT enter RUN from reset without a subsequent start pulse.

Structure
REQ-031 SHALL place the state enum (IDLE, RUN, DONE) and the PC_W/CNT_W defaults in a shared processor package.
REQ-032 SHALL contain no sub-module; the lookup table is instantiated beside this block at processor top level, with lut_key and lut_value connected to it.
REQ-033 SHALL keep next-pc selection combinational and hold all state in a single clocked process.

Verification
REQ-034 Reset then start, with no control inputs for 5 cycles -> pc sequence 0,1,2,3,4,5; cycle_count = 5; done = 0.
REQ-035 In RUN at pc = 7, jump_en = 1, key_in = 3, table entry 3 = 8'h2A -> lut_key = 3 in the same cycle; pc = 42 next cycle; jump_en and branch_en together also yield 42.
REQ-036 At pc = 2, branch_en with lut_value = 8'hFC -> pc = 1022; from pc = 1023 with no controls -> pc = 0.
REQ-037 At pc = 9, stall held for 3 cycles -> pc stays 9, cycle_count advances by 3; stall together with jump_en -> pc still 9.
REQ-038 At pc = 20, halt_req -> done = 1 next cycle, pc holds 20; a later start -> pc = 0, cycle_count = 0, done = 0.
REQ-039 Reset asserted mid-RUN at pc = 15 together with start -> next cycle state IDLE, pc = 0, cycle_count = 0; also, cycle_count forced to FFFF -> further RUN cycles keep it at FFFF.
